// File: rtl/bmem_pkg.sv
// Shared definitions for the CPU-to-DRAM request queue.
// Holds burst geometry, default sizing, the queued request entry and the
// dispatch state encoding used by bmem_req_queue and its FIFO.
package bmem_pkg;

  localparam int BURST_LEN     = 4;
  localparam int BW            = $clog2(BURST_LEN);
  localparam int DEF_QDEPTH    = 4;
  localparam int DEF_MAX_OUTST = 8;

  // One queued request; reads carry a zero data field.
  typedef struct packed {
    logic [31:0]                 addr;
    logic                        is_write;
    logic [BURST_LEN-1:0][63:0]  data;
  } req_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    WR_BEAT  = 2'd2
  } disp_state_t;

endpackage

// File: rtl/bmem_req_fifo.sv
// Purpose: generic in-order storage FIFO for queued memory requests.
// Latency: an entry pushed in cycle N is visible at head_dat in cycle N+1.
// Backpressure: caller checks count before pushing; a push into a full FIFO is dropped.
// Ports: clk/rst, push/push_dat (enqueue), pop (dequeue head),
//        head_dat (oldest entry), count (occupancy), empty.
module bmem_req_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_dat,
  input  logic                       pop,
  output entry_t                     head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/bmem_req_queue.sv
// Purpose: buffers CPU read/write-burst requests and dispatches them in order to DRAM.
// Latency: a request accepted in cycle N drives dram_* in cycle N+1; responses forwarded 1 cycle later.
// Backpressure: cpu_bmem_ready drops when the queue is full or a write burst is in flight; responses have none.
// Ports: cpu_bmem_* request/response toward the CPU, dram_* request/response
//        toward DRAM, proto_err sticky CPU protocol violation flag.
module bmem_req_queue
  import bmem_pkg::*;
#(
  parameter int QDEPTH    = DEF_QDEPTH,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_bmem_addr,
  input  logic        cpu_bmem_read,
  input  logic        cpu_bmem_write,
  input  logic [63:0] cpu_bmem_wdata,
  output logic        cpu_bmem_ready,
  output logic [31:0] cpu_bmem_raddr,
  output logic [63:0] cpu_bmem_rdata,
  output logic        cpu_bmem_rvalid,
  output logic [31:0] dram_addr,
  output logic        dram_read,
  output logic        dram_write,
  output logic [63:0] dram_wdata,
  input  logic        dram_ready,
  input  logic [31:0] dram_raddr,
  input  logic [63:0] dram_rdata,
  input  logic        dram_rvalid,
  output logic        proto_err
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  // CPU-side write burst assembly; wr_cnt is the next expected beat, 0 = idle.
  logic [BW-1:0]              wr_cnt;
  logic [31:0]                wr_addr;
  logic [BURST_LEN-2:0][63:0] wr_data;
  logic                       in_burst;
  logic                       wr_start;
  logic                       wr_last;
  logic                       rd_acc;
  logic                       burst_err;

  logic                       push;
  req_entry_t                 push_dat;
  logic                       pop;
  req_entry_t                 head;
  logic [CW-1:0]              fifo_count;
  logic                       fifo_empty;

  disp_state_t                state, state_nxt;
  logic [BW-1:0]              db, db_nxt;
  logic                       look_vld;
  logic                       look_is_write;
  logic                       rd_issue;

  logic [OW-1:0]              outst;
  logic [BW-1:0]              rbeat;
  logic                       rsp_dec;

  assign in_burst       = (wr_cnt != '0);
  assign cpu_bmem_ready = !rst && (fifo_count < CW'(QDEPTH)) && !in_burst;
  assign wr_start       = cpu_bmem_write && cpu_bmem_ready;
  assign rd_acc         = cpu_bmem_read && !cpu_bmem_write && cpu_bmem_ready;
  assign wr_last        = in_burst && (wr_cnt == BW'(BURST_LEN - 1));
  // Space was reserved at beat 0, so the entry is only written once complete.
  assign push           = rd_acc || wr_last;
  assign burst_err      = (cpu_bmem_read && cpu_bmem_write) ||
                          (in_burst && (!cpu_bmem_write || (cpu_bmem_addr != wr_addr)));

  always_comb begin
    push_dat = '0;
    if (wr_last) begin
      push_dat.addr     = wr_addr;
      push_dat.is_write = 1'b1;
      push_dat.data     = {cpu_bmem_wdata, wr_data};
    end else begin
      push_dat.addr     = cpu_bmem_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (wr_start) begin
        wr_cnt     <= BW'(1);
        wr_addr    <= cpu_bmem_addr;
        wr_data[0] <= cpu_bmem_wdata;
      end else if (in_burst) begin
        // Beats 1-3 are consumed every cycle whether or not write is held.
        wr_cnt <= wr_cnt + BW'(1);
        if (!wr_last) wr_data[wr_cnt] <= cpu_bmem_wdata;
      end
      if (burst_err) proto_err <= 1'b1;
    end
  end

  bmem_req_fifo #(
    .DEPTH   (QDEPTH),
    .entry_t (req_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  // When the FIFO is empty, IDLE decides on the entry being pushed this cycle
  // so a fresh request reaches DRAM one cycle after acceptance.
  assign look_vld      = !fifo_empty || push;
  assign look_is_write = fifo_empty ? wr_last : head.is_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      db    <= '0;
    end else begin
      state <= state_nxt;
      db    <= db_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    db_nxt     = db;
    pop        = 1'b0;
    rd_issue   = 1'b0;
    dram_read  = 1'b0;
    dram_write = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    case (state)
      IDLE: begin
        if (look_vld) begin
          if (look_is_write) begin
            state_nxt = WR_BEAT;
            db_nxt    = '0;
          end else if (outst < OW'(MAX_OUTST)) begin
            state_nxt = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        dram_read = 1'b1;
        dram_addr = head.addr;
        if (dram_ready) begin
          pop       = 1'b1;
          rd_issue  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_BEAT: begin
        dram_write = 1'b1;
        dram_addr  = head.addr;
        dram_wdata = head.data[db];
        // Only beat 0 waits for DRAM; the rest stream unconditionally.
        if ((db != '0) || dram_ready) begin
          db_nxt = db + BW'(1);
          if (db == BW'(BURST_LEN - 1)) begin
            pop       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Floor at zero so responses to reads issued before a reset are not counted.
  assign rsp_dec = dram_rvalid && (rbeat == BW'(BURST_LEN - 1)) && (outst != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_bmem_rvalid <= 1'b0;
      cpu_bmem_raddr  <= '0;
      cpu_bmem_rdata  <= '0;
      rbeat           <= '0;
      outst           <= '0;
    end else begin
      cpu_bmem_rvalid <= dram_rvalid;
      cpu_bmem_raddr  <= dram_raddr;
      cpu_bmem_rdata  <= dram_rdata;
      if (dram_rvalid) rbeat <= rbeat + BW'(1);
      if (rd_issue && !rsp_dec)      outst <= outst + OW'(1);
      else if (!rd_issue && rsp_dec) outst <= outst - OW'(1);
    end
  end

endmodule

// File: tb/tb_bmem_req_queue.sv
// Directed bench for bmem_req_queue: reset, read dispatch/response, write
// burst under DRAM stall, queue-full backpressure, outstanding limit,
// protocol error flag and reset in the middle of a write burst.
module tb_bmem_req_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_bmem_addr;
  logic        cpu_bmem_read;
  logic        cpu_bmem_write;
  logic [63:0] cpu_bmem_wdata;
  logic        cpu_bmem_ready;
  logic [31:0] cpu_bmem_raddr;
  logic [63:0] cpu_bmem_rdata;
  logic        cpu_bmem_rvalid;
  logic [31:0] dram_addr;
  logic        dram_read;
  logic        dram_write;
  logic [63:0] dram_wdata;
  logic        dram_ready;
  logic [31:0] dram_raddr;
  logic [63:0] dram_rdata;
  logic        dram_rvalid;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  bmem_req_queue #(.QDEPTH(4), .MAX_OUTST(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_bmem_addr   (cpu_bmem_addr),
    .cpu_bmem_read   (cpu_bmem_read),
    .cpu_bmem_write  (cpu_bmem_write),
    .cpu_bmem_wdata  (cpu_bmem_wdata),
    .cpu_bmem_ready  (cpu_bmem_ready),
    .cpu_bmem_raddr  (cpu_bmem_raddr),
    .cpu_bmem_rdata  (cpu_bmem_rdata),
    .cpu_bmem_rvalid (cpu_bmem_rvalid),
    .dram_addr       (dram_addr),
    .dram_read       (dram_read),
    .dram_write      (dram_write),
    .dram_wdata      (dram_wdata),
    .dram_ready      (dram_ready),
    .dram_raddr      (dram_raddr),
    .dram_rdata      (dram_rdata),
    .dram_rvalid     (dram_rvalid),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_bmem_addr  = '0;
    cpu_bmem_read  = 1'b0;
    cpu_bmem_write = 1'b0;
    cpu_bmem_wdata = '0;
    dram_ready     = 1'b0;
    dram_raddr     = '0;
    dram_rdata     = '0;
    dram_rvalid    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (cpu_bmem_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", cpu_bmem_ready); end
    checks++; if (dram_read !== 1'b0 || dram_write !== 1'b0) begin errors++; $display("FAIL rst_dram_rw: got %b%b expected 00", dram_read, dram_write); end
    checks++; if (cpu_bmem_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", cpu_bmem_rvalid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b expected 0", proto_err); end
    checks++; if (dram_addr !== 32'h0) begin errors++; $display("FAIL rst_dram_addr: got %h expected 0", dram_addr); end
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (cpu_bmem_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", cpu_bmem_ready); end
  endtask

  task automatic test_read();
    do_reset();
    dram_ready    = 1'b1;
    cpu_bmem_addr = 32'h0000_1000;
    cpu_bmem_read = 1'b1;
    step();
    cpu_bmem_read = 1'b0;
    cpu_bmem_addr = '0;
    checks++; if (dram_read !== 1'b1 || dram_addr !== 32'h1000) begin errors++; $display("FAIL rd_issue: got read=%b addr=%h expected read=1 addr=00001000", dram_read, dram_addr); end
    step();
    checks++; if (dram_read !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b expected 0", dram_read); end
    for (int i = 0; i < 4; i++) begin
      dram_rvalid = 1'b1;
      dram_raddr  = 32'h1000;
      dram_rdata  = 64'hD0 + 64'(i);
      if (i == 0) begin
        #1;
        checks++; if (cpu_bmem_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rsp_delay: got %b expected 0", cpu_bmem_rvalid); end
      end
      step();
      checks++;
      if (cpu_bmem_rvalid !== 1'b1 || cpu_bmem_rdata !== 64'hD0 + 64'(i) || cpu_bmem_raddr !== 32'h1000) begin
        errors++; $display("FAIL rd_rsp_beat%0d: got v=%b a=%h d=%h expected v=1 a=00001000 d=%h", i, cpu_bmem_rvalid, cpu_bmem_raddr, cpu_bmem_rdata, 64'hD0 + 64'(i));
      end
    end
    dram_rvalid = 1'b0;
    step();
    checks++; if (cpu_bmem_rvalid !== 1'b0) begin errors++; $display("FAIL rd_rsp_end: got %b expected 0", cpu_bmem_rvalid); end
  endtask

  task automatic test_write_stall();
    logic [63:0] wb [4];
    wb = '{64'h11, 64'h22, 64'h33, 64'h44};
    do_reset();
    dram_ready     = 1'b0;
    cpu_bmem_write = 1'b1;
    cpu_bmem_addr  = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      cpu_bmem_wdata = wb[i];
      step();
      if (i == 0) begin
        checks++; if (cpu_bmem_ready !== 1'b0) begin errors++; $display("FAIL wr_midburst_ready: got %b expected 0", cpu_bmem_ready); end
      end
    end
    cpu_bmem_write = 1'b0;
    cpu_bmem_addr  = '0;
    cpu_bmem_wdata = '0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (dram_write !== 1'b1 || dram_wdata !== 64'h11 || dram_addr !== 32'h2000) begin
        errors++; $display("FAIL wr_beat0_hold%0d: got w=%b a=%h d=%h expected w=1 a=00002000 d=11", c, dram_write, dram_addr, dram_wdata);
      end
      if (c == 3) dram_ready = 1'b1;
      step();
    end
    for (int b = 1; b < 4; b++) begin
      dram_ready = 1'b0;
      checks++;
      if (dram_write !== 1'b1 || dram_wdata !== wb[b]) begin
        errors++; $display("FAIL wr_beat%0d: got w=%b d=%h expected w=1 d=%h", b, dram_write, dram_wdata, wb[b]);
      end
      step();
    end
    checks++; if (dram_write !== 1'b0) begin errors++; $display("FAIL wr_done: got %b expected 0", dram_write); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cpu_bmem_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, cpu_bmem_ready); end
      cpu_bmem_read = 1'b1;
      cpu_bmem_addr = 32'h100 + 32'(i) * 32'h20;
      step();
    end
    checks++; if (cpu_bmem_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b expected 0", cpu_bmem_ready); end
    cpu_bmem_addr = 32'h180;
    step();
    checks++;
    if (cpu_bmem_ready !== 1'b0 || dram_read !== 1'b1 || dram_addr !== 32'h100) begin
      errors++; $display("FAIL b2b_held: got rdy=%b rd=%b a=%h expected rdy=0 rd=1 a=00000100", cpu_bmem_ready, dram_read, dram_addr);
    end
    dram_ready = 1'b1;
    step();
    dram_ready = 1'b0;
    checks++; if (cpu_bmem_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %b expected 1", cpu_bmem_ready); end
    step();
    cpu_bmem_read = 1'b0;
    cpu_bmem_addr = '0;
    checks++; if (cpu_bmem_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_refull: got %b expected 0", cpu_bmem_ready); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (dram_read !== 1'b1 || dram_addr !== 32'h100 + 32'(i) * 32'h20) begin
        errors++; $display("FAIL b2b_order%0d: got rd=%b a=%h expected rd=1 a=%h", i, dram_read, dram_addr, 32'h100 + 32'(i) * 32'h20);
      end
      dram_ready = 1'b1;
      step();
      dram_ready = 1'b0;
      step();
    end
    checks++; if (dram_read !== 1'b0 || cpu_bmem_ready !== 1'b1) begin errors++; $display("FAIL b2b_drained: got rd=%b rdy=%b expected rd=0 rdy=1", dram_read, cpu_bmem_ready); end
  endtask

  task automatic test_max_outst();
    do_reset();
    dram_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_bmem_read = 1'b1;
      cpu_bmem_addr = 32'h3000 + 32'(i) * 32'h20;
      step();
      cpu_bmem_read = 1'b0;
      checks++;
      if (dram_read !== 1'b1 || dram_addr !== 32'h3000 + 32'(i) * 32'h20) begin
        errors++; $display("FAIL mo_issue%0d: got rd=%b a=%h expected rd=1 a=%h", i, dram_read, dram_addr, 32'h3000 + 32'(i) * 32'h20);
      end
      step();
    end
    cpu_bmem_read = 1'b1;
    cpu_bmem_addr = 32'h3100;
    step();
    cpu_bmem_read = 1'b0;
    cpu_bmem_addr = '0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (dram_read !== 1'b0) begin errors++; $display("FAIL mo_blocked%0d: got %b expected 0", c, dram_read); end
      step();
    end
    for (int b = 0; b < 4; b++) begin
      dram_rvalid = 1'b1;
      dram_raddr  = 32'h3000;
      dram_rdata  = 64'(b);
      step();
      checks++; if (dram_read !== 1'b0) begin errors++; $display("FAIL mo_rsp_beat%0d: got %b expected 0", b, dram_read); end
    end
    dram_rvalid = 1'b0;
    step();
    checks++;
    if (dram_read !== 1'b1 || dram_addr !== 32'h3100) begin
      errors++; $display("FAIL mo_ninth: got rd=%b a=%h expected rd=1 a=00003100", dram_read, dram_addr);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    dram_ready     = 1'b0;
    cpu_bmem_write = 1'b1;
    cpu_bmem_addr  = 32'h4000;
    cpu_bmem_wdata = 64'h1;
    step();
    cpu_bmem_wdata = 64'h2;
    step();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL pe_clean: got %b expected 0", proto_err); end
    cpu_bmem_addr  = 32'h4020;
    cpu_bmem_wdata = 64'h3;
    step();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_addr_change: got %b expected 1", proto_err); end
    cpu_bmem_wdata = 64'h4;
    step();
    idle_inputs();
    checks++;
    if (dram_write !== 1'b1 || dram_addr !== 32'h4000 || dram_wdata !== 64'h1) begin
      errors++; $display("FAIL pe_enqueued: got w=%b a=%h d=%h expected w=1 a=00004000 d=1", dram_write, dram_addr, dram_wdata);
    end
    dram_ready = 1'b1;
    repeat (9) step();
    checks++; if (proto_err !== 1'b1 || dram_write !== 1'b0) begin errors++; $display("FAIL pe_sticky: got pe=%b w=%b expected pe=1 w=0", proto_err, dram_write); end
    do_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL pe_cleared: got %b expected 0", proto_err); end
    cpu_bmem_write = 1'b1;
    cpu_bmem_read  = 1'b1;
    cpu_bmem_addr  = 32'h4400;
    step();
    cpu_bmem_read = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_rd_wr: got %b expected 1", proto_err); end
    repeat (3) step();
    idle_inputs();
    checks++; if (dram_write !== 1'b1 || dram_addr !== 32'h4400) begin errors++; $display("FAIL pe_rd_wr_burst: got w=%b a=%h expected w=1 a=00004400", dram_write, dram_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dram_ready     = 1'b1;
    cpu_bmem_write = 1'b1;
    cpu_bmem_addr  = 32'h5000;
    for (int i = 0; i < 4; i++) begin
      cpu_bmem_wdata = 64'hA1 + 64'(i);
      step();
    end
    cpu_bmem_write = 1'b0;
    cpu_bmem_addr  = '0;
    checks++; if (dram_write !== 1'b1 || dram_wdata !== 64'hA1) begin errors++; $display("FAIL rm_beat0: got w=%b d=%h expected w=1 d=a1", dram_write, dram_wdata); end
    step();
    step();
    checks++; if (dram_write !== 1'b1 || dram_wdata !== 64'hA3) begin errors++; $display("FAIL rm_beat2: got w=%b d=%h expected w=1 d=a3", dram_write, dram_wdata); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dram_write !== 1'b0 || dram_addr !== 32'h0) begin errors++; $display("FAIL rm_async_clear: got w=%b a=%h expected w=0 a=0", dram_write, dram_addr); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (cpu_bmem_ready !== 1'b1 || dram_write !== 1'b0) begin errors++; $display("FAIL rm_release: got rdy=%b w=%b expected rdy=1 w=0", cpu_bmem_ready, dram_write); end
    for (int b = 0; b < 4; b++) begin
      dram_rvalid = 1'b1;
      dram_raddr  = 32'h6000;
      dram_rdata  = 64'hE0 + 64'(b);
      step();
      checks++;
      if (cpu_bmem_rvalid !== 1'b1 || cpu_bmem_rdata !== 64'hE0 + 64'(b)) begin
        errors++; $display("FAIL rm_stale_rsp%0d: got v=%b d=%h expected v=1 d=%h", b, cpu_bmem_rvalid, cpu_bmem_rdata, 64'hE0 + 64'(b));
      end
    end
    dram_rvalid   = 1'b0;
    cpu_bmem_read = 1'b1;
    cpu_bmem_addr = 32'h7000;
    step();
    cpu_bmem_read = 1'b0;
    checks++; if (dram_read !== 1'b1 || dram_addr !== 32'h7000) begin errors++; $display("FAIL rm_floor: got rd=%b a=%h expected rd=1 a=00007000", dram_read, dram_addr); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_back_to_back();
    test_max_outst();
    test_proto_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
